// File: rtl/drum_voice_ctrl.sv
// drum_voice_ctrl: sequences one drum voice. A trigger restarts the oscillator,
// then a pitch divider emits phase-step pulses while an envelope divider ticks
// an attack/decay amplitude. The oscillator sample is scaled by the envelope.
// Optional build macro: PITCH_SWEEP_EN -- each decay tick lengthens the pitch
// period by one (saturating), applied at the next pitch-counter wrap.
module drum_voice_ctrl #(
  parameter int ATTACK_STEP = 32,
  parameter int DIV_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig,
  input  logic [DIV_W-1:0] pitch_div,
  input  logic [DIV_W-1:0] decay_div,
  input  logic [7:0]       wave_in,
  output logic             phase_rst,
  output logic             step_en,
  output logic [7:0]       env,
  output logic             busy,
  output logic [7:0]       voice_out
);

  typedef enum logic [1:0] {IDLE, START, ATTACK, DECAY} state_t;

  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [8:0]       STEP9 = 9'(ATTACK_STEP);

  state_t             state;
  logic [DIV_W-1:0]   pdiv_q, ddiv_q, pcnt, ecnt;
  logic [DIV_W-1:0]   p_base, d_per, p_per, p_per_nx, pcnt_nx, ecnt_nx;
  logic               run, p_wrap, env_tick, step_nx;
  logic [8:0]         att_sum;
  logic signed [8:0]  smp, amp;
  logic signed [17:0] prod;
  logic [7:0]         scaled;
  logic               unused_prod;

`ifdef PITCH_SWEEP_EN
  logic [DIV_W-1:0]   p_add, p_add_pend;
`endif

  function automatic logic [DIV_W-1:0] sat_add(input logic [DIV_W-1:0] a,
                                               input logic [DIV_W-1:0] b);
    logic [DIV_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DIV_W] ? '1 : s[DIV_W-1:0];
  endfunction

  // Divider periods, next counter values, envelope step and sample scaling
  always_comb begin
    p_base = (pdiv_q == '0) ? ONE : pdiv_q;
    d_per  = (ddiv_q == '0) ? ONE : ddiv_q;
`ifdef PITCH_SWEEP_EN
    p_per  = sat_add(p_base, p_add);
`else
    p_per  = p_base;
`endif
    run      = (state == ATTACK) || (state == DECAY);
    p_wrap   = run && (pcnt == p_per - ONE);
    env_tick = run && (ecnt == d_per - ONE);
    pcnt_nx  = p_wrap ? '0 : pcnt + ONE;
    ecnt_nx  = env_tick ? '0 : ecnt + ONE;
`ifdef PITCH_SWEEP_EN
    // a lengthened period only becomes visible once the counter wraps
    p_per_nx = p_wrap ? sat_add(p_base, p_add_pend) : p_per;
`else
    p_per_nx = p_per;
`endif
    // step_en is registered, so it is decided from next cycle's count
    step_nx  = (pcnt_nx == p_per_nx - ONE);
    att_sum  = {1'b0, env} + STEP9;
    // offset binary to signed: flip the MSB and sign-extend
    smp      = $signed({~wave_in[7], ~wave_in[7], wave_in[6:0]});
    amp      = $signed({1'b0, env});
    prod     = 18'(smp) * 18'(amp);
    // bits [15:8] are the floor of prod/256; the result always fits a signed byte
    scaled   = prod[15:8] ^ 8'h80;
    unused_prod = ^{prod[17:16], prod[7:0]};
  end

  // Voice FSM with its counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      env       <= '0;
      busy      <= 1'b0;
      phase_rst <= 1'b0;
      step_en   <= 1'b0;
      voice_out <= 8'h80;
      pcnt      <= '0;
      ecnt      <= '0;
      pdiv_q    <= '0;
      ddiv_q    <= '0;
`ifdef PITCH_SWEEP_EN
      p_add      <= '0;
      p_add_pend <= '0;
`endif
    end else if (trig) begin
      // a trigger restarts the note from any state and beats a same-cycle tick
      state     <= START;
      phase_rst <= 1'b1;
      busy      <= 1'b1;
      env       <= '0;
      step_en   <= 1'b0;
      voice_out <= 8'h80;
      pcnt      <= '0;
      ecnt      <= '0;
      pdiv_q    <= pitch_div;
      ddiv_q    <= decay_div;
`ifdef PITCH_SWEEP_EN
      p_add      <= '0;
      p_add_pend <= '0;
`endif
    end else begin
      phase_rst <= 1'b0;
      case (state)
        IDLE: begin
          env       <= '0;
          busy      <= 1'b0;
          step_en   <= 1'b0;
          voice_out <= 8'h80;
        end
        START: begin
          state     <= ATTACK;
          step_en   <= (p_per == ONE);
          voice_out <= scaled;
        end
        default: begin
          pcnt      <= pcnt_nx;
          ecnt      <= ecnt_nx;
          step_en   <= step_nx;
          voice_out <= scaled;
`ifdef PITCH_SWEEP_EN
          if (p_wrap) p_add <= p_add_pend;
          if ((state == DECAY) && env_tick) p_add_pend <= sat_add(p_add_pend, ONE);
`endif
          if (env_tick) begin
            if (state == ATTACK) begin
              if (att_sum >= 9'h0FF) begin
                env   <= 8'hFF;
                state <= DECAY;
              end else begin
                env <= att_sum[7:0];
              end
            end else begin
              env <= env - 8'd1;
              if (env == 8'd1) begin
                state     <= IDLE;
                busy      <= 1'b0;
                step_en   <= 1'b0;
                voice_out <= 8'h80;
                pcnt      <= '0;
                ecnt      <= '0;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drum_voice_ctrl.sv
// tb_drum_voice_ctrl: directed notes for drum_voice_ctrl (default build, ATTACK_STEP=64).
// Stimulus pushes expected events (phase_rst, step_en, env changes, busy edges,
// sampled voice_out) into queues; a negedge monitor pops and compares them.
module tb_drum_voice_ctrl;
  localparam int ASTEP = 64;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          reset, trig;
  logic [DW-1:0] pitch_div, decay_div;
  logic [7:0]    wave_in;
  logic          phase_rst, step_en, busy;
  logic [7:0]    env, voice_out;

  drum_voice_ctrl #(.ATTACK_STEP(ASTEP), .DIV_W(DW)) dut (
    .clk(clk), .reset(reset), .trig(trig), .pitch_div(pitch_div),
    .decay_div(decay_div), .wave_in(wave_in), .phase_rst(phase_rst),
    .step_en(step_en), .env(env), .busy(busy), .voice_out(voice_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; int v; } ev_t;
  typedef struct { int c; int env; int busy; int step; int vo; } smp_t;

  ev_t  q_step[$], q_prst[$], q_env[$], q_busy[$], q_vo[$];
  smp_t q_smp[$];

  int         n_cmp = 0, n_bad = 0;
  bit         mon_en = 1'b0;
  logic [7:0] env_prev;
  logic       busy_prev;
  ev_t        me;
  smp_t       ms;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, $signed(act), $signed(exp));
    end
  endtask

  // Expected events of one note triggered at negedge t; a = first cycle no longer
  // belonging to this note (0 = note runs to its natural end).
  task automatic note(input int t, input int p, input int d, input int a,
                      input bit rst_abort, input bit busy_was);
    int pe, de, acc, n, endc, slim, elim, last;
    int env_c[$];
    int env_v[$];
    pe = (p == 0) ? 1 : p;
    de = (d == 0) ? 1 : d;
    acc = 0; n = 0; last = 0;
    while (acc < 255) begin
      n++;
      acc = acc + ASTEP;
      if (acc > 255) acc = 255;
      env_c.push_back(t + 2 + de * n);
      env_v.push_back(acc);
    end
    for (int m = 1; m <= 255; m++) begin
      env_c.push_back(t + 2 + de * (n + m));
      env_v.push_back(255 - m);
    end
    endc = t + 2 + de * (n + 255);
    slim = (a != 0) ? a : endc;
    elim = (a != 0) ? a : endc + 1;
    q_prst.push_back('{t + 1, 1});
    if (!busy_was) q_busy.push_back('{t + 1, 1});
    for (int c = t + 1 + pe; c < slim; c += pe) q_step.push_back('{c, 1});
    for (int i = 0; i < env_c.size(); i++) begin
      if (env_c[i] < elim) begin
        q_env.push_back('{env_c[i], env_v[i]});
        last = env_v[i];
      end
    end
    if (a != 0) begin
      if (last != 0) q_env.push_back('{a, 0});
      if (rst_abort) q_busy.push_back('{a, 0});
    end else begin
      q_busy.push_back('{endc, 0});
    end
  endtask

  task automatic drain(input string tag);
    chk({tag, "_pending_step"}, q_step.size(), 0);
    chk({tag, "_pending_prst"}, q_prst.size(), 0);
    chk({tag, "_pending_env"},  q_env.size(),  0);
    chk({tag, "_pending_busy"}, q_busy.size(), 0);
    chk({tag, "_pending_vo"},   q_vo.size(),   0);
    chk({tag, "_pending_smp"},  q_smp.size(),  0);
    q_step.delete(); q_prst.delete(); q_env.delete();
    q_busy.delete(); q_vo.delete(); q_smp.delete();
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every output event pops the matching expectation
  always @(negedge clk) begin
    if (mon_en) begin
      if (q_smp.size() > 0 && q_smp[0].c == cyc) begin
        ms = q_smp.pop_front();
        chk("smp_env", env, ms.env);
        chk("smp_busy", busy, ms.busy);
        chk("smp_step_en", step_en, ms.step);
        chk("smp_voice_out", voice_out, ms.vo);
      end
      if (q_vo.size() > 0 && q_vo[0].c == cyc) begin
        me = q_vo.pop_front();
        chk("voice_out", voice_out, me.v);
      end
      if (phase_rst !== 1'b0) begin
        me = '{-1, 0};
        if (q_prst.size() > 0) me = q_prst.pop_front();
        chk("phase_rst_cycle", cyc, me.c);
      end
      if (step_en !== 1'b0) begin
        me = '{-1, 0};
        if (q_step.size() > 0) me = q_step.pop_front();
        chk("step_en_cycle", cyc, me.c);
      end
      if (env !== env_prev) begin
        me = '{-1, -1};
        if (q_env.size() > 0) me = q_env.pop_front();
        chk("env_cycle", cyc, me.c);
        chk("env_value", env, me.v);
      end
      if (busy !== busy_prev) begin
        me = '{-1, -1};
        if (q_busy.size() > 0) me = q_busy.pop_front();
        chk("busy_edge_cycle", cyc, me.c);
        chk("busy_edge_value", busy, me.v);
      end
      env_prev  = env;
      busy_prev = busy;
    end
  end

  initial begin
    int t, t2;
    reset = 1'b1; trig = 1'b0; pitch_div = '0; decay_div = '0; wave_in = 8'h80;
    repeat (3) @(negedge clk);
    env_prev = 8'h00; busy_prev = 1'b0; mon_en = 1'b1;
    q_smp.push_back('{cyc + 1, 0, 0, 0, 128});
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 20; i++) q_smp.push_back('{cyc + i, 0, 0, 0, 128});
    repeat (22) @(negedge clk);
    drain("idle");

    // main note: P=4, D=2
    pitch_div = 16'd4; decay_div = 16'd2;
    t = cyc;
    note(t, 4, 2, 0, 1'b0, 1'b0);
    trig = 1'b1; @(negedge clk); trig = 1'b0;
    wait_to(t + 530);
    drain("main");

    // zero dividers behave as 1
    pitch_div = 16'd0; decay_div = 16'd0;
    t = cyc;
    note(t, 0, 0, 0, 1'b0, 1'b0);
    trig = 1'b1; @(negedge clk); trig = 1'b0;
    wait_to(t + 270);
    drain("div0");

    // scaling with a slow envelope, then reset during DECAY
    pitch_div = 16'd4; decay_div = 16'd300;
    t = cyc;
    note(t, 4, 300, t + 1311, 1'b1, 1'b0);
    trig = 1'b1; @(negedge clk); trig = 1'b0;
    wait_to(t + 700);
    wave_in = 8'hFF; q_vo.push_back('{cyc + 1, 8'hBF});
    @(negedge clk); wave_in = 8'h00; q_vo.push_back('{cyc + 1, 8'h40});
    @(negedge clk); wave_in = 8'h80; q_vo.push_back('{cyc + 1, 8'h80});
    wait_to(t + 1300);
    wave_in = 8'hFF; q_vo.push_back('{cyc + 1, 8'hFE});
    @(negedge clk); wave_in = 8'h00; q_vo.push_back('{cyc + 1, 8'h00});
    @(negedge clk); wave_in = 8'h80; q_vo.push_back('{cyc + 1, 8'h80});
    @(negedge clk); wave_in = 8'h40; q_vo.push_back('{cyc + 1, 8'h40});
    wait_to(t + 1309);
    wave_in = 8'hFF; q_vo.push_back('{cyc + 1, 8'hFE});
    q_smp.push_back('{t + 1311, 0, 0, 0, 128});
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; wave_in = 8'h80;
    repeat (10) @(negedge clk);
    drain("scale");

    // reset during ATTACK, with a trigger in the same cycle that must be ignored
    pitch_div = 16'd4; decay_div = 16'd2;
    t = cyc;
    note(t, 4, 2, t + 6, 1'b1, 1'b0);
    trig = 1'b1; @(negedge clk); trig = 1'b0;
    wait_to(t + 4);
    q_smp.push_back('{t + 6, 0, 0, 0, 128});
    @(negedge clk); reset = 1'b1; trig = 1'b1;
    @(negedge clk); reset = 1'b0; trig = 1'b0;
    repeat (10) @(negedge clk);
    drain("rst_attack");

    // retrigger while env=0x90 in DECAY
    t = cyc;
    note(t, 4, 2, t + 233, 1'b0, 1'b0);
    trig = 1'b1; @(negedge clk); trig = 1'b0;
    wait_to(t + 231);
    q_smp.push_back('{t + 232, 8'h90, 1, 0, 128});
    @(negedge clk);
    t2 = cyc;
    note(t2, 4, 2, 0, 1'b0, 1'b1);
    q_smp.push_back('{t2 + 1, 0, 1, 0, 128});
    trig = 1'b1; @(negedge clk); trig = 1'b0;
    wait_to(t2 + 530);
    drain("retrig");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/drum_voice_ctrl.md
Name: drum_voice_ctrl

Overview:
Sequences one drum voice: on a trigger it restarts the wavetable oscillator, produces the oscillator's phase-step enables, and runs an attack/decay amplitude envelope. It also scales the oscillator's 8-bit offset-binary sample by the envelope. It sits between the pattern/trigger logic and the sine/noise sources, driving their step and reset inputs and feeding the output mixer.

Parameters:
ATTACK_STEP, 32, envelope increment per envelope tick in ATTACK (legal 1..255)
DIV_W, 16, width of pitch_div/decay_div and their internal counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
trig  in  1  one-cycle voice trigger; ignored in a cycle where reset=1
pitch_div  in  DIV_W  clk cycles per oscillator phase step; sampled in START
decay_div  in  DIV_W  clk cycles per envelope tick; sampled in START
wave_in  in  8  oscillator sample, offset binary (0x80 = zero)
phase_rst  out  1  one-cycle pulse in START; drives the oscillator's reset
step_en  out  1  one-cycle pulse advancing the oscillator's table index
env  out  8  current envelope amplitude
busy  out  1  high in START, ATTACK and DECAY
voice_out  out  8  scaled sample, offset binary

Behaviour:
- One clock; reset is synchronous and active-high. Reset values: state=IDLE, env=0x00, busy=0, phase_rst=0, step_en=0, voice_out=0x80, both counters 0, latched dividers 0.
- States: IDLE, START, ATTACK, DECAY. Outputs are registered and reflect the current state.
- IDLE: env=0, step_en=0, voice_out=0x80. trig -> START.
- START (exactly 1 cycle): phase_rst=1, busy=1, env=0, both counters cleared, pitch_div/decay_div latched -> ATTACK.
- A latched divider of 0 is treated as 1.
- Pitch counter: runs only in ATTACK/DECAY. Counts 0..P-1. step_en=1 in the cycle the count equals P-1, then the counter wraps to 0. First pulse is in the P-th cycle after START.
- Envelope counter: same rule with period D, producing an internal env tick.
- ATTACK: on each tick, env = min(env+ATTACK_STEP, 0xFF) using 9-bit saturating add. The tick that writes 0xFF moves to DECAY.
- DECAY: on each tick, env = env-1. The tick that writes 0x00 moves to IDLE, and busy falls in that same cycle.
- Retrigger: trig in START/ATTACK/DECAY -> START next cycle. env restarts from 0 and no tick is lost or duplicated for the old note. trig coinciding with an env tick: the trig wins.
- Scaling: s = wave_in - 128 (signed 9 bit). p = s * env (signed 17 bit). voice_out = 128 + (p >>> 8), using arithmetic shift (floor). Result is always in 0x00..0xFE, so no clamp is needed.
- voice_out latency: 1 cycle from wave_in/env to voice_out in ATTACK/DECAY. In IDLE/START it is forced to 0x80.
- Reset mid-note: the next cycle is IDLE with all reset values. No phase_rst pulse is generated.

Optional Feature:
PITCH_SWEEP_EN:
- Defined: the effective pitch period P starts at the latched pitch_div. Each DECAY env tick increments P by 1, saturating at 2^DIV_W-1, which gives a kick-drum pitch drop. A new P takes effect at the next counter wrap.
- Undefined: P is constant for the whole note, and the sweep logic is absent.

Test Plan:
- Reset, then idle 20 cycles -> env=0, busy=0, step_en=0, voice_out=0x80, phase_rst never asserts.
- ATTACK_STEP=64, pitch_div=4, decay_div=2, trig once:
  - phase_rst high exactly 1 cycle.
  - env sequence 0x40, 0x80, 0xC0, 0xFF every 2 cycles, then decrements every 2 cycles.
  - busy high for exactly 1+8+510=519 cycles.
  - step_en every 4th cycle starting 4 cycles after START.
- Scaling, env held at 0xFF: wave_in=0xFF -> voice_out=0xFE, wave_in=0x00 -> 0x00, wave_in=0x80 -> 0x80. With env=0x80 and wave_in=0xFF -> 0xBF. Each appears 1 cycle after input.
- pitch_div=0, decay_div=0 -> step_en high every ATTACK/DECAY cycle and env ticks every cycle. busy lasts 1+8+255=264 cycles with ATTACK_STEP=32.
- Retrigger while env=0x90 in DECAY -> START next cycle (phase_rst=1, env=0x00), then a full attack. Reset asserted in ATTACK -> IDLE next cycle, voice_out=0x80, busy=0.
- PITCH_SWEEP_EN, pitch_div=4, decay_div=2, ATTACK_STEP=255 -> step_en spacing grows from 4 to 5, 6, … cycles as DECAY ticks accumulate. Undefined: spacing stays at 4 for the whole note.
